// File: rtl/instruction_fetch_controller_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_controller_if
//   Bundles the three handshaked buses of the fetch controller:
//     - instruction memory read port (imem_address / imem_instruction)
//     - decode-side FIFO head (if_valid / if_ready / if_instruction / if_pc)
//     - debug read port (dbg_req / dbg_addr / dbg_ack / dbg_data)
//   master : the fetch controller
//   slave  : the surrounding system (memory, decode stage, debugger)
// ----------------------------------------------------------------------------
interface instruction_fetch_controller_if;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;

    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_data;

    modport master (
        output imem_address,
        input  imem_instruction,
        output if_valid,
        input  if_ready,
        output if_instruction,
        output if_pc,
        input  dbg_req,
        input  dbg_addr,
        output dbg_ack,
        output dbg_data
    );

    modport slave (
        input  imem_address,
        output imem_instruction,
        input  if_valid,
        output if_ready,
        input  if_instruction,
        input  if_pc,
        output dbg_req,
        output dbg_addr,
        input  dbg_ack,
        input  dbg_data
    );
endinterface

// File: rtl/instruction_fetch_controller.sv
// ----------------------------------------------------------------------------
// instruction_fetch_controller
//   Owns the program counter and sequences a combinational single-port
//   instruction memory. Fetched words go into a 2-entry FIFO toward decode.
//   Branch redirects flush the FIFO and reload the PC; halt stops fetching.
//   A debug read port shares the memory port through an arbiter that lets
//   fetch win until the debugger has waited DBG_MAX_WAIT cycles.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   bus (master)    : imem read port, decode FIFO head, debug read port
//   redirect_valid  : 1-cycle redirect pulse, target in redirect_pc
//   halt            : level, stops fetch issue while high
//   misaligned_err  : sticky, set by a redirect target with [1:0] != 0
// ----------------------------------------------------------------------------
module instruction_fetch_controller #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned DBG_MAX_WAIT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    instruction_fetch_controller_if.master  bus,
    input  logic                            redirect_valid,
    input  logic [31:0]                     redirect_pc,
    input  logic                            halt,
    output logic                            misaligned_err
);

    localparam int unsigned WAIT_W = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_RESET,
        S_RUN,
        S_HALTED
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       fifo_pc_q  [2];
    logic [31:0]       fifo_pc_d  [2];
    logic [31:0]       fifo_ins_q [2];
    logic [31:0]       fifo_ins_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [31:0]       dbg_data_q, dbg_data_d;
    logic              misaligned_q, misaligned_d;

    logic head_valid;
    logic deq;
    logic fetch_want;
    logic dbg_grant;
    logic fetch;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        head_valid = (count_q != 2'd0);
        deq        = head_valid && bus.if_ready;
        // A dequeue in the same cycle frees a slot, so a full FIFO can still fetch.
        fetch_want = (state_q == S_RUN) && !redirect_valid && ((count_q != 2'd2) || deq);
        // Debug wins whenever fetch is idle, or steals the port once starved.
        dbg_grant  = bus.dbg_req && !dbg_ack_q
                     && (!fetch_want || (wait_q == WAIT_W'(DBG_MAX_WAIT)));
        fetch      = fetch_want && !dbg_grant;

        state_d      = state_q;
        pc_d         = pc_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_ins_d   = fifo_ins_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        wait_d       = wait_q;
        dbg_ack_d    = dbg_grant;
        dbg_data_d   = dbg_data_q;
        misaligned_d = misaligned_q;

        unique case (state_q)
            S_RESET:  state_d = halt ? S_HALTED : S_RUN;
            S_RUN:    if (halt)  state_d = S_HALTED;
            S_HALTED: if (!halt) state_d = S_RUN;
            default:  state_d = S_RESET;
        endcase

        if (fetch) begin
            fifo_pc_d[wr_ptr_q]  = pc_q;
            fifo_ins_d[wr_ptr_q] = bus.imem_instruction;
        end

        if (redirect_valid) begin
            // Flush wins over any same-cycle enqueue/dequeue bookkeeping.
            rd_ptr_d     = 1'b0;
            wr_ptr_d     = 1'b0;
            count_d      = 2'd0;
            pc_d         = {redirect_pc[31:2], 2'b00};
            misaligned_d = misaligned_q || (redirect_pc[1:0] != 2'b00);
        end else begin
            if (fetch) begin
                wr_ptr_d = ~wr_ptr_q;
                pc_d     = pc_q + 32'd4;
            end
            if (deq) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(fetch) - 2'(deq);
        end

        if (dbg_grant) begin
            dbg_data_d = bus.imem_instruction;
            wait_d     = '0;
        end else if (bus.dbg_req && !dbg_ack_q && (wait_q != WAIT_W'(DBG_MAX_WAIT))) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RESET;
            pc_q         <= RESET_PC;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            wait_q       <= '0;
            dbg_ack_q    <= 1'b0;
            dbg_data_q   <= 32'h0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            wait_q       <= wait_d;
            dbg_ack_q    <= dbg_ack_d;
            dbg_data_q   <= dbg_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the head outputs are
    // gated by if_valid, so stale contents can never reach decode.
    always_ff @(posedge clk) begin
        fifo_pc_q  <= fifo_pc_d;
        fifo_ins_q <= fifo_ins_d;
    end

    assign bus.imem_address   = dbg_grant ? bus.dbg_addr : pc_q;
    assign bus.if_valid       = head_valid;
    assign bus.if_pc          = head_valid ? fifo_pc_q[rd_ptr_q]  : 32'h0;
    assign bus.if_instruction = head_valid ? fifo_ins_q[rd_ptr_q] : 32'h0;
    assign bus.dbg_ack        = dbg_ack_q;
    assign bus.dbg_data       = dbg_data_q;
    assign misaligned_err     = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_controller
//   Directed bench for instruction_fetch_controller. The instruction memory
//   returns 0xA000_0000 + word index, so every expected word is A0..An.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge. Accepted decode handshakes are logged in a queue.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        misaligned_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] acc_pc  [$];
    logic [31:0] acc_ins [$];

    instruction_fetch_controller_if bus ();

    instruction_fetch_controller #(
        .RESET_PC     (32'h0000_0000),
        .DBG_MAX_WAIT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .misaligned_err (misaligned_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    assign bus.imem_instruction = instr_of(bus.imem_address);

    always @(negedge clk) begin
        if (!rst && bus.if_valid && bus.if_ready) begin
            acc_pc.push_back(bus.if_pc);
            acc_ins.push_back(bus.if_instruction);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Holds rst for two edges and returns in the first post-reset cycle.
    task automatic do_reset();
        next();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        bus.dbg_req    = 1'b0;
        repeat (2) next();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] q_pc(input int i);
        return (i < acc_pc.size()) ? acc_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] q_ins(input int i);
        return (i < acc_ins.size()) ? acc_ins[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ack_at;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        bus.if_ready   = 1'b1;
        bus.dbg_req    = 1'b0;
        bus.dbg_addr   = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        neg();
        check("rst_if_valid",   32'(bus.if_valid),   32'h0);
        check("rst_if_pc",      bus.if_pc,           32'h0);
        check("rst_if_instr",   bus.if_instruction,  32'h0);
        check("rst_dbg_ack",    32'(bus.dbg_ack),    32'h0);
        check("rst_dbg_data",   bus.dbg_data,        32'h0);
        check("rst_misaligned", 32'(misaligned_err), 32'h0);
        check("rst_imem_addr",  bus.imem_address,    32'h0);

        // 1: streaming from reset, first head two cycles after release
        do_reset();
        neg();
        check("t1_valid_c0", 32'(bus.if_valid), 32'h0);
        next(); neg();
        check("t1_valid_c1", 32'(bus.if_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next();
            if (i == 0) begin
                next();
            end
            neg();
            check($sformatf("t1_valid%0d", i), 32'(bus.if_valid), 32'h1);
            check($sformatf("t1_pc%0d", i),    bus.if_pc,          32'(4 * i));
            check($sformatf("t1_ins%0d", i),   bus.if_instruction, 32'hA000_0000 + 32'(i));
        end

        // 2: decode stalled, FIFO fills with 0,4 and the PC parks at 8
        bus.if_ready = 1'b0;
        do_reset();
        repeat (6) next();
        neg();
        check("t2_full_valid", 32'(bus.if_valid), 32'h1);
        check("t2_full_pc",    bus.if_pc,         32'h0);
        check("t2_imem_addr",  bus.imem_address,  32'h8);
        next(); neg();
        check("t2_hold_pc",    bus.if_pc,         32'h0);
        check("t2_hold_addr",  bus.imem_address,  32'h8);
        next();
        acc_pc.delete(); acc_ins.delete();
        bus.if_ready = 1'b1;
        repeat (4) next();
        check("t2_count", 32'(acc_pc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_pc%0d", i), q_pc(i), 32'(4 * i));
        end

        // 3: redirect with two entries buffered
        bus.if_ready = 1'b0;
        do_reset();
        repeat (6) next();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        next();
        redirect_valid = 1'b0;
        neg();
        check("t3_flushed", 32'(bus.if_valid), 32'h0);
        next(); neg();
        check("t3_valid", 32'(bus.if_valid),   32'h1);
        check("t3_pc",    bus.if_pc,           32'h40);
        check("t3_ins",   bus.if_instruction,  32'hA000_0010);
        next();
        acc_pc.delete(); acc_ins.delete();
        bus.if_ready = 1'b1;
        repeat (3) next();
        check("t3_count", 32'(acc_pc.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_pc%0d", i), q_pc(i), 32'h40 + 32'(4 * i));
        end

        // 4: debug read during continuous streaming is forced after 4 waits
        do_reset();
        repeat (4) next();
        acc_pc.delete(); acc_ins.delete();
        bus.dbg_addr = 32'h10;
        bus.dbg_req  = 1'b1;
        ack_at = -1;
        for (int k = 0; k < 10; k++) begin
            neg();
            if (k == 4) check("t4_grant_addr", bus.imem_address, 32'h10);
            if (ack_at >= 0 && k == ack_at + 1) check("t4_ack_pulse", 32'(bus.dbg_ack), 32'h0);
            if (bus.dbg_ack && ack_at < 0) begin
                ack_at = k;
                check("t4_dbg_data", bus.dbg_data, 32'hA000_0004);
            end
            next();
            if (ack_at >= 0) bus.dbg_req = 1'b0;
        end
        check("t4_ack_latency", 32'(ack_at), 32'd5);
        check("t4_count", 32'(acc_pc.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t4_pc%0d", i),  q_pc(i),  32'h8 + 32'(4 * i));
            check($sformatf("t4_ins%0d", i), q_ins(i), instr_of(32'h8 + 32'(4 * i)));
        end
        check("t4_misaligned", 32'(misaligned_err), 32'h0);

        // 5: misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        next();
        redirect_valid = 1'b0;
        acc_pc.delete(); acc_ins.delete();
        neg();
        check("t5_misaligned", 32'(misaligned_err), 32'h1);
        check("t5_flushed",    32'(bus.if_valid),   32'h0);
        repeat (3) next();
        check("t5_count", 32'(acc_pc.size()), 32'd2);
        check("t5_pc0",   q_pc(0), 32'h40);
        check("t5_pc1",   q_pc(1), 32'h44);
        repeat (5) next();
        neg();
        check("t5_sticky", 32'(misaligned_err), 32'h1);

        // 6: halt, drain, debug read while halted, reset mid-request
        next();
        acc_pc.delete(); acc_ins.delete();
        halt = 1'b1;
        neg();
        check("t6_h0_pc", bus.if_pc, 32'h60);
        next(); neg();
        check("t6_h1_valid", 32'(bus.if_valid), 32'h1);
        check("t6_h1_pc",    bus.if_pc,         32'h64);
        next(); neg();
        check("t6_drained",  32'(bus.if_valid), 32'h0);
        check("t6_pc_park",  bus.imem_address,  32'h68);
        next();
        check("t6_count", 32'(acc_pc.size()), 32'd2);
        check("t6_last",  q_pc(1), 32'h64);
        bus.dbg_addr = 32'h8;
        bus.dbg_req  = 1'b1;
        neg();
        check("t6_dbg_addr",  bus.imem_address, 32'h8);
        check("t6_ack_early", 32'(bus.dbg_ack), 32'h0);
        next(); neg();
        check("t6_ack",       32'(bus.dbg_ack), 32'h1);
        check("t6_dbg_data",  bus.dbg_data,     32'hA000_0002);
        next();
        bus.dbg_req = 1'b0;
        neg();
        check("t6_ack_drop",  32'(bus.dbg_ack), 32'h0);
        check("t6_still_idle", 32'(bus.if_valid), 32'h0);
        next();
        bus.dbg_addr = 32'hC;
        bus.dbg_req  = 1'b1;
        rst          = 1'b1;
        neg();
        next(); neg();
        check("t6_rst_ack",        32'(bus.dbg_ack),    32'h0);
        check("t6_rst_dbg_data",   bus.dbg_data,        32'h0);
        check("t6_rst_misaligned", 32'(misaligned_err), 32'h0);
        check("t6_rst_valid",      32'(bus.if_valid),   32'h0);
        check("t6_rst_pc",         bus.if_pc,           32'h0);
        check("t6_rst_ins",        bus.if_instruction,  32'h0);
        next();
        bus.dbg_req = 1'b0;
        halt        = 1'b0;
        next();
        rst = 1'b0;
        neg();
        check("t6_restart_c0", 32'(bus.if_valid), 32'h0);
        next(); neg();
        check("t6_restart_c1", 32'(bus.if_valid), 32'h0);
        next(); neg();
        check("t6_restart_valid", 32'(bus.if_valid),   32'h1);
        check("t6_restart_pc",    bus.if_pc,           32'h0);
        check("t6_restart_ins",   bus.if_instruction,  32'hA000_0000);
        check("t6_restart_ack",   32'(bus.dbg_ack),    32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
